regunit_bus_master: RTL and testbench
=====================================

Name: regunit_bus_master

Overview:
- Command-side controller for the 8-bit mode-driven register unit on the shared tristate bus.
- Accepts host commands (mode + optional load data + optional readback) and generates the mode_input and output_control sequence. Drives the bus for parallel loads.
- Samples the bus on readback and returns the raw value plus a gray-to-binary decoded value.
- Sits between a host/testbench FSM and one register unit; guarantees no bus contention.

Parameters:
- WIDTH, 8, bus and data width.
- DECODE_GRAY, 1, when 1 decode readback after gray ops (011/100); when 0 rsp_bin = rsp_raw always.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  host command valid
- cmd_ready  output  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready at clk edge
- cmd_mode  input  3  mode to apply (000 hold, 001 rotr, 010 rotl, 011 gray up, 100 gray down, 101 not, 110 nibble swap, 111 load)
- cmd_data  input  WIDTH  load value, used only when cmd_mode==111
- cmd_read  input  1  1 = read back register output after the op
- io_bus  inout  WIDTH  shared bus to register unit
- mode_out  output  3  to register unit mode_input
- output_control  output  1  to register unit; enables its bus driver
- busy  output  1  ~cmd_ready
- rsp_valid  output  1  one-cycle pulse, readback result valid
- rsp_raw  output  WIDTH  bus value captured at end of READ
- rsp_bin  output  WIDTH  decoded value (see Behaviour)

Behaviour:
- Reset (async, immediate): state=IDLE; bus driver off (io_bus Z); mode_out=000; output_control=0; rsp_valid=0; rsp_raw=rsp_bin=0; cmd_ready=1.
- Command fields latched on acceptance. cmd_valid while busy is ignored (not queued).
- States:
  - IDLE: mode 000, no driver, output_control 0. Accept: mode 111 -> TURN_W; otherwise -> EXEC.
  - TURN_W: one dead cycle, all drivers off, mode 000. -> DRIVE.
  - DRIVE: io_bus=latched data, mode_out=111 for exactly one cycle; register loads at the closing edge. -> TURN_R if read, else IDLE.
  - EXEC: mode_out=latched mode for exactly one cycle, bus not driven. -> READ if read, else IDLE.
  - TURN_R: one dead cycle, mode 000, no drivers. -> READ.
  - READ: output_control=1, mode 000, controller driver off. io_bus captured into rsp_raw at the closing edge. -> IDLE, with rsp_valid=1 in the following cycle.
- READ directly follows EXEC with no gap. This is mandatory: the register unit overwrites its gray output with binary on the next hold cycle.
- Invariant: the controller's driver enable and output_control are never both 1 in any cycle. At least one cycle with both 0 between them.
- Latency from accept edge to rsp_valid:
  - non-load op: 3 cycles (EXEC, READ, pulse)
  - load op: 5 cycles (TURN_W, DRIVE, TURN_R, READ, pulse)
- Decode: if DECODE_GRAY=1 and latched mode is 011 or 100, then rsp_bin[W-1]=raw[W-1] and rsp_bin[i]=rsp_bin[i+1]^raw[i]. Otherwise rsp_bin=rsp_raw.
- rsp_raw and rsp_bin hold until the next capture. A new command may be accepted in the same cycle rsp_valid is high.
- Reset mid-operation, in any state: bus released and outputs return to reset values asynchronously. In-flight command dropped; no rsp_valid.
- Unknown/Z on io_bus during READ is captured as-is; no checking.

Test Plan:
- Load 0xA5 with read -> io_bus=0xA5 for exactly one cycle with mode_out=111; output_control high one cycle; rsp_raw=rsp_bin=0xA5, rsp_valid 5 cycles after accept.
- Load 0x02, then gray up with read -> register a=0x03; rsp_raw=0x02, rsp_bin=0x03, rsp_valid 3 cycles after accept.
- Load 0x00, then gray down with read -> wrap to 0xFF; rsp_raw=0x80, rsp_bin=0xFF.
- Load 0x81, rotr with read -> rsp_raw=rsp_bin=0xC0. Then nibble swap with read -> 0x0C. Then not with read -> 0xF3.
- Assert reset during DRIVE -> io_bus Z in the same cycle, mode_out=000, cmd_ready=1, no rsp_valid. Next load 0x3C succeeds.
- Hold cmd_valid high through a command with new fields -> only the first command executes, next accepted on return to IDLE. Assertion check: driver enable and output_control never both high across all tests.

Source files
------------

// File: rtl/regunit_bus_master.sv
// Command-side controller for a mode-driven register unit on a shared tristate bus.
// Sequences mode/output_control, drives parallel loads, and captures gray-decoded readback.
module regunit_bus_master #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DECODE_GRAY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_read,
    inout  wire  [WIDTH-1:0] io_bus,
    output logic [2:0]       mode_out,
    output logic             output_control,
    output logic             busy,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_raw,
    output logic [WIDTH-1:0] rsp_bin
);

    typedef enum logic [2:0] {StIdle, StTurnW, StDrive, StExec, StTurnR, StRead} state_e;

    localparam logic [2:0] ModeHold  = 3'b000;
    localparam logic [2:0] ModeGrayU = 3'b011;
    localparam logic [2:0] ModeGrayD = 3'b100;
    localparam logic [2:0] ModeLoad  = 3'b111;

    state_e           r_state;
    state_e           w_state_next;
    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_data;
    logic             r_read;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_raw;
    logic [WIDTH-1:0] r_rsp_bin;
    logic             w_drv_en;
    logic             w_accept;
    logic             w_gray;
    logic [WIDTH-1:0] w_bin;

    assign w_accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (cmd_valid) begin
                    w_state_next = (cmd_mode == ModeLoad) ? StTurnW : StExec;
                end
            end
            StTurnW: w_state_next = StDrive;
            StDrive: w_state_next = r_read ? StTurnR : StIdle;
            // READ must follow EXEC immediately: the unit replaces gray output on the next hold.
            StExec:  w_state_next = r_read ? StRead : StIdle;
            StTurnR: w_state_next = StRead;
            StRead:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready      = 1'b0;
        mode_out       = ModeHold;
        output_control = 1'b0;
        w_drv_en       = 1'b0;
        unique case (r_state)
            StIdle:  cmd_ready = 1'b1;
            StDrive: begin
                mode_out = ModeLoad;
                w_drv_en = 1'b1;
            end
            StExec:  mode_out = r_mode;
            StRead:  output_control = 1'b1;
            default: ;
        endcase
    end

    assign busy   = ~cmd_ready;
    assign io_bus = w_drv_en ? r_data : {WIDTH{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= ModeHold;
            r_data <= '0;
            r_read <= 1'b0;
        end else if (w_accept) begin
            r_mode <= cmd_mode;
            r_data <= cmd_data;
            r_read <= cmd_read;
        end
    end

    assign w_gray = (DECODE_GRAY != 0) && ((r_mode == ModeGrayU) || (r_mode == ModeGrayD));

    // Binary bit i is the XOR of all gray bits from the MSB down to i.
    always_comb begin
        w_bin = io_bus;
        if (w_gray) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                w_bin[i] = ^(io_bus >> i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_raw   <= '0;
            r_rsp_bin   <= '0;
        end else begin
            r_rsp_valid <= (r_state == StRead);
            if (r_state == StRead) begin
                r_rsp_raw <= io_bus;
                r_rsp_bin <= w_bin;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_raw   = r_rsp_raw;
    assign rsp_bin   = r_rsp_bin;

endmodule

// File: tb/tb_regunit_bus_master.sv
// Directed bench for regunit_bus_master with a behavioural 8-bit register unit on the bus.
module tb_regunit_bus_master;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_mode;
    logic [7:0] cmd_data;
    logic       cmd_read;
    wire  [7:0] bus;
    logic [2:0] mode_out;
    logic       output_control;
    logic       busy;
    logic       rsp_valid;
    logic [7:0] rsp_raw;
    logic [7:0] rsp_bin;

    int n_checks = 0;
    int n_err    = 0;

    regunit_bus_master #(.WIDTH(8), .DECODE_GRAY(1)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_mode       (cmd_mode),
        .cmd_data       (cmd_data),
        .cmd_read       (cmd_read),
        .io_bus         (bus),
        .mode_out       (mode_out),
        .output_control (output_control),
        .busy           (busy),
        .rsp_valid      (rsp_valid),
        .rsp_raw        (rsp_raw),
        .rsp_bin        (rsp_bin)
    );

    always #5 clk = ~clk;

    // Register unit model: gray ops leave gray on the output until the next hold cycle.
    logic [7:0] m_a;
    logic       m_g;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a <= 8'h00;
            m_g <= 1'b0;
        end else begin
            m_g <= 1'b0;
            case (mode_out)
                3'b001: m_a <= {m_a[0], m_a[7:1]};
                3'b010: m_a <= {m_a[6:0], m_a[7]};
                3'b011: begin m_a <= m_a + 8'h01; m_g <= 1'b1; end
                3'b100: begin m_a <= m_a - 8'h01; m_g <= 1'b1; end
                3'b101: m_a <= ~m_a;
                3'b110: m_a <= {m_a[3:0], m_a[7:4]};
                3'b111: m_a <= bus;
                default: ;
            endcase
        end
    end
    assign bus = output_control ? (m_g ? (m_a ^ (m_a >> 1)) : m_a) : 8'hzz;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) check_eq("excl", {31'd0, dut.w_drv_en & output_control}, 32'd0);
    end

    task automatic run_cmd(input string tag, input logic [2:0] mode, input logic [7:0] data,
                           input logic rd, input logic [7:0] exp_raw, input logic [7:0] exp_bin);
        int lat = 0, n_mode = 0, n_oc = 0, n_drv = 0, exp_lat;
        logic [7:0] bus_seen = 8'h00;
        bit done = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = mode; cmd_data = data; cmd_read = rd;
        @(posedge clk);
        for (int k = 1; k <= 12 && !done; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (mode_out != 3'b000) n_mode++;
            if (output_control) n_oc++;
            if (dut.w_drv_en) begin n_drv++; bus_seen = bus; end
            if (rsp_valid) lat = k;
            if (cmd_ready) done = 1;
        end
        exp_lat = rd ? ((mode == 3'b111) ? 5 : 3) : 0;
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_lat"}, lat, exp_lat);
        check_eq({tag, "_nmode"}, n_mode, 1);
        check_eq({tag, "_noc"}, n_oc, 32'(rd));
        check_eq({tag, "_ndrv"}, n_drv, (mode == 3'b111) ? 1 : 0);
        if (mode == 3'b111) check_eq({tag, "_busval"}, 32'(bus_seen), 32'(data));
        if (rd) begin
            check_eq({tag, "_raw"}, 32'(rsp_raw), 32'(exp_raw));
            check_eq({tag, "_bin"}, 32'(rsp_bin), 32'(exp_bin));
            @(negedge clk);
            check_eq({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int n_rv;
        bit seen;
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 3'b000; cmd_data = 8'h00; cmd_read = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mode", 32'(mode_out), 32'd0);
        check_eq("rst_oc", 32'(output_control), 32'd0);
        check_eq("rst_drv", 32'(dut.w_drv_en), 32'd0);
        check_eq("rst_rv", 32'(rsp_valid), 32'd0);
        check_eq("rst_raw", 32'(rsp_raw), 32'd0);
        check_eq("rst_bin", 32'(rsp_bin), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_cmd("ldA5", 3'b111, 8'hA5, 1'b1, 8'hA5, 8'hA5);
        run_cmd("ld02", 3'b111, 8'h02, 1'b0, 8'h00, 8'h00);
        run_cmd("gup", 3'b011, 8'h00, 1'b1, 8'h02, 8'h03);
        run_cmd("ld00", 3'b111, 8'h00, 1'b0, 8'h00, 8'h00);
        run_cmd("gdn", 3'b100, 8'h00, 1'b1, 8'h80, 8'hFF);
        run_cmd("ld81", 3'b111, 8'h81, 1'b0, 8'h00, 8'h00);
        run_cmd("rotr", 3'b001, 8'h00, 1'b1, 8'hC0, 8'hC0);
        run_cmd("swap", 3'b110, 8'h00, 1'b1, 8'h0C, 8'h0C);
        run_cmd("not", 3'b101, 8'h00, 1'b1, 8'hF3, 8'hF3);
        run_cmd("rotl", 3'b010, 8'h00, 1'b1, 8'hE7, 8'hE7);

        // Reset in the middle of a load drive cycle.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 3'b111; cmd_data = 8'h99; cmd_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_drive_mode", 32'(mode_out), 32'd7);
        check_eq("mid_drive_drv", 32'(dut.w_drv_en), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("mid_rst_drv", 32'(dut.w_drv_en), 32'd0);
        check_eq("mid_rst_mode", 32'(mode_out), 32'd0);
        check_eq("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_oc", 32'(output_control), 32'd0);
        check_eq("mid_rst_raw", 32'(rsp_raw), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_rv = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) n_rv++;
        end
        check_eq("mid_rst_norsp", n_rv, 0);
        run_cmd("ld3C", 3'b111, 8'h3C, 1'b1, 8'h3C, 8'h3C);

        // cmd_valid held high with changing fields: first command runs as latched.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_mode = 3'b001; cmd_data = 8'h55; cmd_read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("hold_exec1", 32'(mode_out), 32'd1);
        cmd_mode = 3'b010; cmd_data = 8'hAA;
        seen = 0;
        for (int k = 2; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1;
                check_eq("hold_lat1", k, 3);
            end
        end
        check_eq("hold_seen1", 32'(seen), 32'd1);
        check_eq("hold_raw1", 32'(rsp_raw), 32'h1E);
        check_eq("hold_ready1", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_eq("hold_exec2", 32'(mode_out), 32'd2);
        seen = 0;
        for (int k = 2; k <= 10 && !seen; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check_eq("hold_seen2", 32'(seen), 32'd1);
        check_eq("hold_raw2", 32'(rsp_raw), 32'h3C);
        check_eq("hold_bin2", 32'(rsp_bin), 32'h3C);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
